// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: funct3 access
//                encodings, the sequencing state type and the access-size
//                helper used by both the request check and the beat counter.
//  Contents    : F3_B/F3_H/F3_W/F3_BU/F3_HU  funct3 encodings
//                lsu_state_e                 IDLE / ACCESS / RESP
//                size_of()                   bytes per access (0 = illegal)
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Number of bytes moved by an access; 0 flags an encoding with no meaning
  // for either loads or stores.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_ext
//  Description : Combinational load-data formatter. Takes the little-endian
//                assembled bytes of a load and applies sign or zero extension
//                according to the access funct3.
//  Ports       : funct3_i [2:0]   access encoding (b/h/w/bu/hu)
//                bytes_i  [31:0]  assembled bytes, byte 0 in bits [7:0]
//                data_o   [31:0]  extended load result (0 for other codes)
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] bytes_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
      F3_BU:   data_o = {24'd0, bytes_i[7:0]};
      F3_H:    data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
      F3_HU:   data_o = {16'd0, bytes_i[15:0]};
      F3_W:    data_o = bytes_i;
      default: data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Initiator side of the data-memory interface. Accepts one
//                load/store request at a time and sequences it as byte beats
//                over a byte-wide memory port, then reports a one-cycle
//                response with extended load data or an error flag.
//  Parameters  : MEM_BYTES      addressable bytes; accesses reaching beyond
//                               the last byte are rejected without a beat
//  Ports       : clk, rst_n     clock, asynchronous active-low reset
//                req_*_i/_o     core request (valid/ready, we, funct3,
//                               addr, wdata)
//                resp_*_o       response pulse, load data, error flag
//                mem_*_o        byte beat: read/write strobe, addr, wdata
//                mem_rdata_i    read byte, valid with mem_ack_i
//                mem_ack_i      current beat completes this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  cnt_q;       // index of the beat currently on the bus
  logic [1:0]  last_q;      // index of the final beat (size - 1)
  logic [31:0] wdata_q;     // store bytes not yet presented, next in [7:0]
  logic [31:0] data_q;      // load bytes collected so far

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  // --------------------------------------------------------------------------
  // Request check and load assembly
  // --------------------------------------------------------------------------
  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_bad;
  logic [31:0] data_d;
  logic [31:0] ext_data;

  always_comb begin
    req_size = size_of(req_funct3_i);
    // 33-bit sum so an access near the top of the address space cannot wrap
    // back into range.
    req_end  = {1'b0, req_addr_i} + {30'd0, req_size} - 33'd1;
    req_bad  = (req_size == 3'd0)
            || (req_we_i && req_funct3_i[2])
            || (req_end >= 33'(MEM_BYTES));
    // Byte arriving this cycle merged in, so the final beat's data can be
    // extended and registered on the same edge that completes it.
    data_d = data_q;
    data_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
  end

  lsu_load_ext u_load_ext (
    .funct3_i (f3_q),
    .bytes_i  (data_d),
    .data_o   (ext_data)
  );

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      wdata_q      <= 32'd0;
      data_q       <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            f3_q        <= req_funct3_i;
            cnt_q       <= 2'd0;
            data_q      <= 32'd0;
            if (req_bad) begin
              // Rejected requests never touch the memory port.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q     <= ST_ACCESS;
              last_q      <= 2'(req_size - 3'd1);
              mem_read_q  <= ~req_we_i;
              mem_write_q <= req_we_i;
              mem_addr_q  <= req_addr_i;
              mem_wdata_q <= req_we_i ? req_wdata_i[7:0] : 8'd0;
              wdata_q     <= {8'd0, req_wdata_i[31:8]};
            end
          end
        end

        ST_ACCESS: begin
          // Without an ack the beat simply holds; there is no timeout.
          if (mem_ack_i) begin
            data_q <= data_d;
            if (cnt_q == last_q) begin
              state_q      <= ST_RESP;
              mem_read_q   <= 1'b0;
              mem_write_q  <= 1'b0;
              mem_addr_q   <= 32'd0;
              mem_wdata_q  <= 8'd0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= we_q ? 32'd0 : ext_data;
            end else begin
              cnt_q       <= cnt_q + 2'd1;
              mem_addr_q  <= mem_addr_q + 32'd1;
              mem_wdata_q <= we_q ? wdata_q[7:0] : 8'd0;
              wdata_q     <= {8'd0, wdata_q[31:8]};
            end
          end
        end

        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end

        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit. A 128-byte
//                behavioural memory answers the byte beats, with an optional
//                stall on one address. Expected values are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Memory model with optional stall on one address
  // --------------------------------------------------------------------------
  logic [7:0]  mem [0:127];
  logic        mem_clear;
  logic        stall_en;
  logic [31:0] stall_addr;
  int          stall_cycles;
  int          held_cnt;
  int          dual_cnt;

  assign mem_rdata = mem_read ? mem[mem_addr[6:0]] : 8'h00;
  assign mem_ack   = (mem_read | mem_write)
                  && !(stall_en && (mem_addr == stall_addr) && (held_cnt < stall_cycles));

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (mem_write && mem_ack) begin
      mem[mem_addr[6:0]] <= mem_wdata;
    end
    if (stall_en && (mem_read | mem_write) && (mem_addr == stall_addr))
      held_cnt <= held_cnt + 1;
    else
      held_cnt <= 0;
  end

  initial dual_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && mem_read && mem_write) dual_cnt <= dual_cnt + 1;
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations of the last transaction.
  logic [31:0] o_rdata;
  logic        o_err;
  int          o_lat;
  int          o_beats;
  int          o_tgt;
  logic        o_ready_resp;
  logic        o_ops_resp;

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Issue one request and follow it to its response. o_lat counts cycles
  // from the accept edge: the first cycle after that edge is cycle 1.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    o_lat   = 1;
    o_beats = 0;
    o_tgt   = 0;
    while (!resp_valid && o_lat < 40) begin
      if (mem_read | mem_write) o_beats++;
      if (mem_read && mem_addr == stall_addr) o_tgt++;
      @(posedge clk); #1;
      o_lat++;
    end
    o_rdata      = resp_rdata;
    o_err        = resp_err;
    o_ready_resp = req_ready;
    o_ops_resp   = mem_read | mem_write;
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_beats);
    do_req(we, f3, addr, wdata);
    check({tag, "_lat"},   32'(o_lat),   32'(exp_lat));
    check({tag, "_rdata"}, o_rdata,      exp_rdata);
    check({tag, "_err"},   {31'd0, o_err}, {31'd0, exp_err});
    check({tag, "_beats"}, 32'(o_beats), 32'(exp_beats));
    check({tag, "_resp_idle"}, {30'd0, o_ready_resp, o_ops_resp}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, resp_valid, req_ready}, 32'd1);
    check({tag, "_hold"},  resp_rdata, exp_rdata);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int rv_seen;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    mem_clear    = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_funct3   = 3'd0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    stall_en     = 1'b0;
    stall_addr   = 32'hFFFF_FFFF;
    stall_cycles = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_outs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_clear = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs",  {20'd0, resp_valid, resp_err, mem_read, mem_write, mem_wdata}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);

    // 1: word store, bytes little-endian.
    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4);
    check("sw10_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

    // 2: loads of the stored word.
    xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 4);
    xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1);

    // 3: unaligned halfwords and a halfword store.
    xact("lh11",  1'b0, 3'b001, 32'h11, 32'h0, 32'hFFFFADBE, 1'b0, 3, 2);
    xact("lhu11", 1'b0, 3'b101, 32'h11, 32'h0, 32'h0000ADBE, 1'b0, 3, 2);
    xact("sh20",  1'b1, 3'b001, 32'h20, 32'hAAAA1234, 32'h0, 1'b0, 3, 2);
    check("sh20_mem", {16'd0, mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h00001234);
    xact("lh20",  1'b0, 3'b001, 32'h20, 32'h0, 32'h00001234, 1'b0, 3, 2);

    // 4: errors and the top-of-memory boundary.
    xact("lw126",  1'b0, 3'b010, 32'd126, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("ld011",  1'b0, 3'b011, 32'h0,   32'h0, 32'h0, 1'b1, 1, 0);
    xact("st100",  1'b1, 3'b100, 32'h0,   32'h0, 32'h0, 1'b1, 1, 0);
    xact("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lh127",  1'b0, 3'b001, 32'd127, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("sb127",  1'b1, 3'b000, 32'd127, 32'h12345680, 32'h0, 1'b0, 2, 1);
    xact("lb127",  1'b0, 3'b000, 32'd127, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1);
    xact("lw124",  1'b0, 3'b010, 32'd124, 32'h0, 32'h80000000, 1'b0, 5, 4);

    // 5: three-cycle stall on beat 1 of a word load.
    stall_en     = 1'b1;
    stall_addr   = 32'h11;
    stall_cycles = 3;
    xact("lwstall", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 8, 7);
    check("lwstall_hold_beats", 32'(o_tgt), 32'd4);
    stall_en     = 1'b0;
    stall_addr   = 32'hFFFF_FFFF;

    // 6: reset while beat 2 of a word store is on the bus.
    wait_ready();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hA1B2C3D4;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    for (int k = 0; k < 10 && mem_addr != 32'h42; k++) begin
      @(posedge clk); #1;
    end
    check("rst6_beat2", mem_addr, 32'h42);
    rst_n = 1'b0;
    #1;
    check("rst6_outs",  {20'd0, resp_valid, resp_err, mem_read, mem_write, mem_wdata}, 32'd0);
    check("rst6_addr",  mem_addr, 32'd0);
    check("rst6_rdata", resp_rdata, 32'd0);
    rv_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) rv_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) rv_seen++;
    end
    check("rst6_no_resp", 32'(rv_seen), 32'd0);
    check("rst6_ready",   {31'd0, req_ready}, 32'd1);
    check("rst6_mem", {8'd0, mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0000C3D4);
    xact("lbu41", 1'b0, 3'b100, 32'h41, 32'h0, 32'h000000C3, 1'b0, 2, 1);
    xact("lw40",  1'b0, 3'b010, 32'h40, 32'h0, 32'h0000C3D4, 1'b0, 5, 4);

    check("rw_exclusive", 32'(dual_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
